aes_axis_egress_downsizer: RTL and testbench

//  Receiving end of the AES-256-CTR core's 128-bit AXI-Stream master port (m_axis_*).

---
 rtl/aes_axis_egress_downsizer.sv | 155 +++++++++++++++
 tb/tb_aes_axis_egress_downsizer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_axis_egress_downsizer.sv
// rtl/aes_axis_egress_downsizer.sv - 128-bit AXI-Stream beat to OUT_W-bit word downsizer
//
// Purpose: receives 128-bit ciphertext beats from the AES-256-CTR core and emits
// each beat as 128/OUT_W narrower words, MSB first, keeping frame boundaries.
// Reports the word count of the last completed frame and a frame-done pulse.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   s_axis_*       128-bit input stream (tvalid/tready/tlast/tdata)
//   m_axis_*       OUT_W-bit output stream (tvalid/tready/tlast/tdata)
//   frame_words    output word count of the last completed frame
//   frame_done     one-cycle pulse after a frame's last word handshakes
//   busy           high while a beat is held or a frame is open
module aes_axis_egress_downsizer #(
  parameter int OUT_W = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tlast,
  input  logic [127:0]     s_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic [OUT_W-1:0] m_axis_tdata,
  output logic [CNT_W-1:0] frame_words,
  output logic             frame_done,
  output logic             busy
);

  localparam int N     = 128 / OUT_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int SH_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  generate
    if (OUT_W != 8 && OUT_W != 16 && OUT_W != 32 && OUT_W != 64 && OUT_W != 128) begin : g_bad_out_w
      $fatal(1, "aes_axis_egress_downsizer: OUT_W must be 8, 16, 32, 64 or 128");
    end
  endgenerate

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [127:0]       hold_q, hold_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               held_last_q, held_last_d;
  logic               in_frame_q, in_frame_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]   frame_words_q, frame_words_d;
  logic               frame_done_q, frame_done_d;

  logic               last_word;
  logic               in_hs;
  logic               out_hs;
  logic [7:0]         shamt;
  logic [127:0]       shifted;

  assign last_word     = (idx_q == LAST_IDX);
  assign m_axis_tvalid = (state_q == SHIFT);
  assign out_hs        = m_axis_tvalid & m_axis_tready;
  // Ready also while the final word leaves so beats stream without a bubble;
  // forced low during reset so no beat is taken while the block is cleared.
  assign s_axis_tready = rst & ((state_q == IDLE) | (out_hs & last_word));
  assign in_hs         = s_axis_tvalid & s_axis_tready;

  // OUT_W is a power of two, so idx*OUT_W is a plain left shift of idx.
  assign shamt         = 8'(idx_q) << SH_W;
  assign shifted       = hold_q << shamt;
  assign m_axis_tdata  = shifted[127 -: OUT_W];
  assign m_axis_tlast  = held_last_q & last_word;

  assign frame_words   = frame_words_q;
  assign frame_done    = frame_done_q;
  assign busy          = (state_q == SHIFT) | in_frame_q;

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    idx_d         = idx_q;
    held_last_d   = held_last_q;
    in_frame_d    = in_frame_q;
    word_cnt_d    = word_cnt_q;
    frame_words_d = frame_words_q;
    frame_done_d  = out_hs & m_axis_tlast;

    case (state_q)
      IDLE: begin
        if (in_hs) begin
          hold_d      = s_axis_tdata;
          held_last_d = s_axis_tlast;
          idx_d       = '0;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (out_hs) begin
          if (!last_word) begin
            idx_d = idx_q + IDX_W'(1);
          end else if (in_hs) begin
            hold_d      = s_axis_tdata;
            held_last_d = s_axis_tlast;
            idx_d       = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (out_hs) begin
      if (m_axis_tlast) begin
        frame_words_d = word_cnt_q + CNT_W'(1);
        word_cnt_d    = '0;
        in_frame_d    = 1'b0;
      end else begin
        word_cnt_d = word_cnt_q + CNT_W'(1);
      end
    end
    // A beat accepted as the previous frame closes opens the next frame.
    if (in_hs) begin
      in_frame_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      hold_q        <= '0;
      idx_q         <= '0;
      held_last_q   <= 1'b0;
      in_frame_q    <= 1'b0;
      word_cnt_q    <= '0;
      frame_words_q <= '0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      idx_q         <= idx_d;
      held_last_q   <= held_last_d;
      in_frame_q    <= in_frame_d;
      word_cnt_q    <= word_cnt_d;
      frame_words_q <= frame_words_d;
      frame_done_q  <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_aes_axis_egress_downsizer.sv
// tb/tb_aes_axis_egress_downsizer.sv - self-checking bench for aes_axis_egress_downsizer
module tb_aes_axis_egress_downsizer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // OUT_W = 32 instance
  logic         s_tvalid, s_tready, s_tlast;
  logic [127:0] s_tdata;
  logic         m_tvalid, m_tready, m_tlast;
  logic [31:0]  m_tdata;
  logic [31:0]  fw;
  logic         fd, busy;

  // OUT_W = 8 instance
  logic         s8_tvalid, s8_tready, s8_tlast;
  logic [127:0] s8_tdata;
  logic         m8_tvalid, m8_tready, m8_tlast;
  logic [7:0]   m8_tdata;
  logic [31:0]  fw8;
  logic         fd8, busy8;

  // OUT_W = 128 instance
  logic         s1_tvalid, s1_tready, s1_tlast;
  logic [127:0] s1_tdata;
  logic         m1_tvalid, m1_tready, m1_tlast;
  logic [127:0] m1_tdata;
  logic [31:0]  fw1;
  logic         fd1, busy1;

  aes_axis_egress_downsizer #(.OUT_W(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tdata(s_tdata),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tdata(m_tdata),
    .frame_words(fw), .frame_done(fd), .busy(busy)
  );

  aes_axis_egress_downsizer #(.OUT_W(8), .CNT_W(32)) dut8 (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s8_tvalid), .s_axis_tready(s8_tready), .s_axis_tlast(s8_tlast), .s_axis_tdata(s8_tdata),
    .m_axis_tvalid(m8_tvalid), .m_axis_tready(m8_tready), .m_axis_tlast(m8_tlast), .m_axis_tdata(m8_tdata),
    .frame_words(fw8), .frame_done(fd8), .busy(busy8)
  );

  aes_axis_egress_downsizer #(.OUT_W(128), .CNT_W(32)) dut1 (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s1_tvalid), .s_axis_tready(s1_tready), .s_axis_tlast(s1_tlast), .s_axis_tdata(s1_tdata),
    .m_axis_tvalid(m1_tvalid), .m_axis_tready(m1_tready), .m_axis_tlast(m1_tlast), .m_axis_tdata(m1_tdata),
    .frame_words(fw1), .frame_done(fd1), .busy(busy1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the DUT is a FIFO of pending narrow words.
  typedef struct { logic [31:0] d; logic last; } word_t;
  typedef struct { logic [127:0] data; logic last; } beat_t;
  typedef struct { logic [127:0] data; logic [31:0] w [4]; } vec_t;

  word_t       expq[$];
  beat_t       src[$];
  logic [31:0] got[$];
  int          got_cyc[$];
  int          wcnt_m;
  logic        inf_m;
  logic [31:0] fw_m;
  logic        fd_m;
  logic        in_hs_m, out_hs_m;
  int          tick = 0;
  int          mode = 0;
  vec_t        tbl [4];

  task automatic model_reset();
    expq.delete();
    src.delete();
    wcnt_m = 0;
    inf_m  = 1'b0;
    fw_m   = '0;
    fd_m   = 1'b0;
  endtask

  task automatic cycle();
    logic         exp_sr, exp_mv;
    logic [127:0] b;
    logic         bl;
    word_t        w;
    @(negedge clk);
    exp_mv = (expq.size() != 0);
    exp_sr = (expq.size() == 0) || (expq.size() == 1 && m_tready);
    chk("s_tready", s_tready, exp_sr);
    chk("m_tvalid", m_tvalid, exp_mv);
    chk("busy", busy, exp_mv || inf_m);
    chk("frame_done", fd, fd_m);
    chk("frame_words", fw, fw_m);
    if (exp_mv) begin
      chk("m_tdata", m_tdata, expq[0].d);
      chk("m_tlast", m_tlast, expq[0].last);
    end
    out_hs_m = exp_mv && m_tready;
    in_hs_m  = s_tvalid && exp_sr;
    b  = s_tdata;
    bl = s_tlast;
    if (out_hs_m) begin
      got.push_back(m_tdata);
      got_cyc.push_back(tick);
    end
    @(posedge clk);
    fd_m = 1'b0;
    if (out_hs_m) begin
      w = expq.pop_front();
      wcnt_m++;
      if (w.last) begin
        fw_m   = 32'(wcnt_m);
        wcnt_m = 0;
        fd_m   = 1'b1;
        inf_m  = 1'b0;
      end
    end
    if (in_hs_m) begin
      for (int k = 0; k < 4; k++) expq.push_back('{b[127-32*k -: 32], bl && (k == 3)});
      inf_m = 1'b1;
    end
    tick++;
    #1;
  endtask

  task automatic drive();
    s_tvalid = (src.size() != 0) && (mode != 2 || $urandom_range(0, 3) != 0);
    s_tdata  = s_tvalid ? src[0].data : {$urandom(), $urandom(), $urandom(), $urandom()};
    s_tlast  = s_tvalid ? src[0].last : 1'($urandom());
    case (mode)
      0:       m_tready = 1'b1;
      1:       m_tready = (tick % 3 == 0);
      default: m_tready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic step();
    drive();
    cycle();
    if (in_hs_m) void'(src.pop_front());
  endtask

  task automatic run(input int maxc);
    int c = 0;
    while (src.size() != 0 || expq.size() != 0 || fd_m) begin
      if (c >= maxc) begin
        checks++;
        errors++;
        $display("FAIL timeout after %0d cycles src=%0d pending=%0d", c, src.size(), expq.size());
        break;
      end
      step();
      c++;
    end
    s_tvalid = 1'b0;
  endtask

  task automatic check_frame(input string name, input int first, input int nbeats);
    chk({name, "_count"}, 128'(got.size()), 128'(4 * nbeats));
    for (int i = 0; i < 4 * nbeats && i < got.size(); i++)
      chk({name, "_word"}, got[i], tbl[first + i / 4].w[i % 4]);
  endtask

  localparam logic [127:0] BEAT5 = 128'h00112233_44556677_8899AABB_CCDDEEFF;

  initial begin
    tbl[0].data = 128'h601EC313_775789A5_B7A7F504_BBF3D228;
    tbl[0].w    = '{32'h601EC313, 32'h775789A5, 32'hB7A7F504, 32'hBBF3D228};
    tbl[1].data = 128'hF443E3CA_4D62B59A_CA84E990_CACAF5C5;
    tbl[1].w    = '{32'hF443E3CA, 32'h4D62B59A, 32'hCA84E990, 32'hCACAF5C5};
    tbl[2].data = 128'h2B0930DA_A23DE94C_E87017BA_2D84988D;
    tbl[2].w    = '{32'h2B0930DA, 32'hA23DE94C, 32'hE87017BA, 32'h2D84988D};
    tbl[3].data = 128'hDFC9C58D_B67AADA6_13C2DD08_457941A6;
    tbl[3].w    = '{32'hDFC9C58D, 32'hB67AADA6, 32'h13C2DD08, 32'h457941A6};

    rst = 1'b0;
    s_tvalid = 0; s_tlast = 0; s_tdata = '0; m_tready = 1;
    s8_tvalid = 0; s8_tlast = 0; s8_tdata = '0; m8_tready = 1;
    s1_tvalid = 0; s1_tlast = 0; s1_tdata = '0; m1_tready = 1;
    model_reset();

    // Reset state
    #1;
    chk("rst_s_tready", s_tready, 1'b0);
    chk("rst_m_tvalid", m_tvalid, 1'b0);
    chk("rst_m_tlast", m_tlast, 1'b0);
    chk("rst_m_tdata", m_tdata, 32'h0);
    chk("rst_frame_words", fw, 32'h0);
    chk("rst_frame_done", fd, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_s_tready", s_tready, 1'b1);

    // OUT_W=8 and OUT_W=128 builds
    s8_tvalid = 1; s8_tdata = BEAT5; s8_tlast = 1;
    s1_tvalid = 1; s1_tdata = BEAT5; s1_tlast = 1;
    @(negedge clk);
    chk("w8_s_tready", s8_tready, 1'b1);
    chk("w128_s_tready", s1_tready, 1'b1);
    @(posedge clk);
    #1;
    s8_tvalid = 0; s1_tvalid = 0;
    for (int k = 0; k < 16; k++) begin
      logic [7:0] e8;
      e8 = 8'(k * 17);
      @(negedge clk);
      chk("w8_tvalid", m8_tvalid, 1'b1);
      chk("w8_tdata", m8_tdata, e8);
      chk("w8_tlast", m8_tlast, k == 15);
      if (k == 0) begin
        chk("w128_tvalid", m1_tvalid, 1'b1);
        chk("w128_tdata", m1_tdata, BEAT5);
        chk("w128_tlast", m1_tlast, 1'b1);
        chk("w128_s_tready_last", s1_tready, 1'b1);
      end
      if (k == 1) begin
        chk("w128_tvalid_after", m1_tvalid, 1'b0);
        chk("w128_frame_done", fd1, 1'b1);
        chk("w128_frame_words", fw1, 32'd1);
      end
      @(posedge clk);
    end
    @(negedge clk);
    chk("w8_tvalid_after", m8_tvalid, 1'b0);
    chk("w8_frame_done", fd8, 1'b1);
    chk("w8_frame_words", fw8, 32'd16);
    @(posedge clk);
    #1;

    // Single beat
    mode = 0;
    got.delete(); got_cyc.delete();
    src.push_back('{tbl[0].data, 1'b1});
    run(50);
    check_frame("single", 0, 1);
    chk("single_frame_words", fw, 32'd4);

    // Four beats back to back, table driven
    got.delete(); got_cyc.delete();
    for (int i = 0; i < 4; i++) src.push_back('{tbl[i].data, i == 3});
    run(100);
    check_frame("b2b", 0, 4);
    if (got_cyc.size() == 16) chk("b2b_gapless", 128'(got_cyc[15] - got_cyc[0]), 128'd15);
    chk("b2b_frame_words", fw, 32'd16);

    // Same frame under 1,0,0 backpressure
    mode = 1;
    got.delete(); got_cyc.delete();
    for (int i = 0; i < 4; i++) src.push_back('{tbl[i].data, i == 3});
    run(200);
    check_frame("bp", 0, 4);
    chk("bp_frame_words", fw, 32'd16);

    // Reset after the second word of a beat
    mode = 0;
    got.delete(); got_cyc.delete();
    src.push_back('{tbl[1].data, 1'b0});
    for (int i = 0; i < 3; i++) step();
    s_tvalid = 0;
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_m_tvalid", m_tvalid, 1'b0);
    chk("mid_rst_s_tready", s_tready, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_frame_words", fw, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    got.delete(); got_cyc.delete();
    src.push_back('{tbl[2].data, 1'b1});
    run(50);
    check_frame("after_rst", 2, 1);
    chk("after_rst_frame_words", fw, 32'd4);

    // Random valid/ready against the model
    mode = 2;
    got.delete(); got_cyc.delete();
    for (int i = 0; i < 3000; i++)
      src.push_back('{{$urandom(), $urandom(), $urandom(), $urandom()}, (i == 2999) || ($urandom_range(0, 3) == 0)});
    run(60000);
    got.delete(); got_cyc.delete();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
